// File: rtl/i2s_codec_serializer.sv
// I2S master: BCLK/LRCK generation, Philips-format DAC serializer and optional ADC capture.
// Optional RX path compiled in with `define I2S_ADC_CAPTURE_EN.
module i2s_codec_serializer #(
    parameter int DATA_W    = 24,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              underrun,
    output logic              aud_bclk,
    output logic              aud_daclrck,
    output logic              aud_adclrck,
    output logic              aud_dacdat,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              rx_valid
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int IDX_W      = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_ZERO     = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF     = DIV_W'(BCLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_PRE_RISE = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO     = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_B       = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_B       = BIT_W'(DATA_W);
    localparam logic [DATA_W-1:0] SAMPLE_ZERO = {DATA_W{1'b0}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [BIT_W-1:0] slot_pos(input logic [BIT_W-1:0] b);
        if (b >= SLOT_B) begin
            slot_pos = b - SLOT_B;
        end else begin
            slot_pos = b;
        end
    endfunction

    function automatic logic in_data(input logic [BIT_W-1:0] p);
        in_data = (p >= BIT_ONE) && (p <= DATA_B);
    endfunction

    logic [1:0]        lock_sync_r;
    logic              lock_s;
    state_t            state_r, state_nx_s;
    logic              run_s;
    logic              accept_s;
    logic              div_wrap_s, frame_start_s;
    logic [DIV_W-1:0]  div_cnt_r, div_nx_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_nx_s, p_nx_s;
    logic [IDX_W-1:0]  idx_s;
    logic              stage_full_r, stage_full_nx_s;
    logic [DATA_W-1:0] stage_l_r, stage_r_r, stage_l_nx_s, stage_r_nx_s;
    logic [DATA_W-1:0] play_l_r, play_r_r, play_l_nx_s, play_r_nx_s;
    logic              tx_ready_r, tx_ready_nx_s;
    logic              underrun_r, underrun_nx_s;
    logic              bclk_r, bclk_nx_s;
    logic              lrck_r, lrck_nx_s;
    logic              dacdat_r, dacdat_nx_s;

    assign lock_s   = lock_sync_r[1];
    assign accept_s = tx_valid && tx_ready_r;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync_r <= 2'b00;
        end else begin
            lock_sync_r <= {lock_sync_r[0], pll_locked};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; run_s marks cycles that stay in RUN and advance the frame.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lock_s) state_nx_s = ST_RUN;
                else        state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!lock_s) state_nx_s = ST_IDLE;
                else         state_nx_s = ST_RUN;
            end
            default: state_nx_s = ST_IDLE;
        endcase
        run_s = (state_r == ST_RUN) && (state_nx_s == ST_RUN);
    end

    // Counters, staging, frame load and next values of all TX-side outputs.
    always_comb begin
        div_wrap_s      = 1'b0;
        frame_start_s   = 1'b0;
        div_nx_s        = DIV_ZERO;
        bit_nx_s        = BIT_ZERO;
        stage_full_nx_s = 1'b0;
        stage_l_nx_s    = SAMPLE_ZERO;
        stage_r_nx_s    = SAMPLE_ZERO;
        play_l_nx_s     = SAMPLE_ZERO;
        play_r_nx_s     = SAMPLE_ZERO;
        underrun_nx_s   = 1'b0;
        dacdat_nx_s     = 1'b0;
        idx_s           = {IDX_W{1'b0}};
        if (run_s) begin
            div_wrap_s      = (div_cnt_r == DIV_LAST);
            frame_start_s   = div_wrap_s && (bit_cnt_r == BIT_LAST);
            stage_full_nx_s = stage_full_r;
            stage_l_nx_s    = stage_l_r;
            stage_r_nx_s    = stage_r_r;
            play_l_nx_s     = play_l_r;
            play_r_nx_s     = play_r_r;
            if (div_wrap_s) begin
                div_nx_s = DIV_ZERO;
                bit_nx_s = (bit_cnt_r == BIT_LAST) ? BIT_ZERO : bit_cnt_r + BIT_ONE;
            end else begin
                div_nx_s = div_cnt_r + DIV_ONE;
                bit_nx_s = bit_cnt_r;
            end
            // Frame load sees staging as it was before any same-cycle accept.
            if (frame_start_s) begin
                if (stage_full_r) begin
                    play_l_nx_s     = stage_l_r;
                    play_r_nx_s     = stage_r_r;
                    stage_full_nx_s = 1'b0;
                end else begin
                    play_l_nx_s   = SAMPLE_ZERO;
                    play_r_nx_s   = SAMPLE_ZERO;
                    underrun_nx_s = 1'b1;
                end
            end else begin
                underrun_nx_s = 1'b0;
            end
            if (accept_s) begin
                stage_full_nx_s = 1'b1;
                stage_l_nx_s    = tx_left;
                stage_r_nx_s    = tx_right;
            end else begin
                stage_full_nx_s = stage_full_nx_s;
            end
        end else begin
            div_wrap_s = 1'b0;
        end
        p_nx_s = slot_pos(bit_nx_s);
        if (run_s && in_data(p_nx_s)) begin
            idx_s       = IDX_W'(DATA_B - p_nx_s);
            dacdat_nx_s = (bit_nx_s >= SLOT_B) ? play_r_nx_s[idx_s] : play_l_nx_s[idx_s];
        end else begin
            dacdat_nx_s = 1'b0;
        end
        tx_ready_nx_s = (state_nx_s == ST_RUN) && !stage_full_nx_s;
        bclk_nx_s     = run_s && (div_nx_s >= DIV_HALF);
        lrck_nx_s     = run_s && (bit_nx_s >= SLOT_B);
    end

    // TX-side registers; every output is taken straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r    <= DIV_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            stage_full_r <= 1'b0;
            stage_l_r    <= SAMPLE_ZERO;
            stage_r_r    <= SAMPLE_ZERO;
            play_l_r     <= SAMPLE_ZERO;
            play_r_r     <= SAMPLE_ZERO;
            tx_ready_r   <= 1'b0;
            underrun_r   <= 1'b0;
            bclk_r       <= 1'b0;
            lrck_r       <= 1'b0;
            dacdat_r     <= 1'b0;
        end else begin
            div_cnt_r    <= div_nx_s;
            bit_cnt_r    <= bit_nx_s;
            stage_full_r <= stage_full_nx_s;
            stage_l_r    <= stage_l_nx_s;
            stage_r_r    <= stage_r_nx_s;
            play_l_r     <= play_l_nx_s;
            play_r_r     <= play_r_nx_s;
            tx_ready_r   <= tx_ready_nx_s;
            underrun_r   <= underrun_nx_s;
            bclk_r       <= bclk_nx_s;
            lrck_r       <= lrck_nx_s;
            dacdat_r     <= dacdat_nx_s;
        end
    end

    assign tx_ready    = tx_ready_r;
    assign underrun    = underrun_r;
    assign aud_bclk    = bclk_r;
    assign aud_daclrck = lrck_r;
    assign aud_adclrck = lrck_r;
    assign aud_dacdat  = dacdat_r;

`ifdef I2S_ADC_CAPTURE_EN
    logic [DATA_W-1:0] rx_l_sh_r, rx_r_sh_r, rx_l_sh_nx_s, rx_r_sh_nx_s;
    logic [DATA_W-1:0] rx_left_r, rx_right_r, rx_left_nx_s, rx_right_nx_s;
    logic              rx_valid_r, rx_valid_nx_s;
    logic              rx_armed_r, rx_armed_nx_s;
    logic [BIT_W-1:0]  p_cur_s;

    // ADC capture on the cycle before BCLK rises; publish the finished frame at frame start.
    always_comb begin
        rx_l_sh_nx_s  = SAMPLE_ZERO;
        rx_r_sh_nx_s  = SAMPLE_ZERO;
        rx_left_nx_s  = SAMPLE_ZERO;
        rx_right_nx_s = SAMPLE_ZERO;
        rx_valid_nx_s = 1'b0;
        rx_armed_nx_s = 1'b0;
        p_cur_s       = slot_pos(bit_cnt_r);
        if (run_s) begin
            rx_l_sh_nx_s  = rx_l_sh_r;
            rx_r_sh_nx_s  = rx_r_sh_r;
            rx_left_nx_s  = rx_left_r;
            rx_right_nx_s = rx_right_r;
            rx_armed_nx_s = rx_armed_r;
            if ((div_cnt_r == DIV_PRE_RISE) && in_data(p_cur_s)) begin
                if (bit_cnt_r >= SLOT_B) begin
                    rx_r_sh_nx_s = {rx_r_sh_r[DATA_W-2:0], aud_adcdat};
                end else begin
                    rx_l_sh_nx_s = {rx_l_sh_r[DATA_W-2:0], aud_adcdat};
                end
            end else begin
                rx_l_sh_nx_s = rx_l_sh_r;
            end
            // The frame captured right after entering RUN is never published.
            if (frame_start_s) begin
                rx_armed_nx_s = 1'b1;
                if (rx_armed_r) begin
                    rx_left_nx_s  = rx_l_sh_r;
                    rx_right_nx_s = rx_r_sh_r;
                    rx_valid_nx_s = 1'b1;
                end else begin
                    rx_valid_nx_s = 1'b0;
                end
            end else begin
                rx_valid_nx_s = 1'b0;
            end
        end else begin
            rx_valid_nx_s = 1'b0;
        end
    end

    // RX registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_l_sh_r  <= SAMPLE_ZERO;
            rx_r_sh_r  <= SAMPLE_ZERO;
            rx_left_r  <= SAMPLE_ZERO;
            rx_right_r <= SAMPLE_ZERO;
            rx_valid_r <= 1'b0;
            rx_armed_r <= 1'b0;
        end else begin
            rx_l_sh_r  <= rx_l_sh_nx_s;
            rx_r_sh_r  <= rx_r_sh_nx_s;
            rx_left_r  <= rx_left_nx_s;
            rx_right_r <= rx_right_nx_s;
            rx_valid_r <= rx_valid_nx_s;
            rx_armed_r <= rx_armed_nx_s;
        end
    end

    assign rx_left  = rx_left_r;
    assign rx_right = rx_right_r;
    assign rx_valid = rx_valid_r;
`else
    logic unused_adcdat_s;
    assign unused_adcdat_s = aud_adcdat;
    assign rx_left  = {DATA_W{1'b0}};
    assign rx_right = {DATA_W{1'b0}};
    assign rx_valid = 1'b0;
`endif

endmodule

// File: doc/i2s_codec_serializer.md
# i2s_codec_serializer

Audio-rate I2S master that sits directly downstream of the audio PLL and runs from its 16.934404 MHz output (384·fs, fs = 44.1 kHz). It derives BCLK and LRCK for the codec and serializes stereo samples from the reverb datapath onto DACDAT through a valid/ready handshake. It also deserializes ADCDAT into stereo samples for the reverb input. It is held idle until the PLL reports lock.

## Interface
Parameters:
- `DATA_W`, 24: sample width per channel (two's complement).
- `SLOT_BITS`, 32: BCLK periods per channel slot; must be ≥ DATA_W+1.
- `BCLK_DIV`, 6: clk cycles per BCLK period; even, ≥ 2. fs = clk / (BCLK_DIV·2·SLOT_BITS).

Ports:
- `clk`  in  1  audio clock, driven from the PLL `outclk_0`.
- `rst`  in  1  reset; asynchronous, active-high.
- `pll_locked`  in  1  PLL lock; asynchronous to `clk`, synchronized internally.
- `tx_left`, `tx_right`  in  DATA_W  stereo sample to play.
- `tx_valid`  in  1  sample pair valid.
- `tx_ready`  out  1  staging register empty; accept on `tx_valid && tx_ready`.
- `underrun`  out  1  one-cycle pulse when a frame starts with no staged sample.
- `aud_bclk`  out  1  bit clock.
- `aud_daclrck`, `aud_adclrck`  out  1  word clock, identical; low = left slot.
- `aud_dacdat`  out  1  serial DAC data.
- `aud_adcdat`  in  1  serial ADC data.
- `rx_left`, `rx_right`  out  DATA_W  last captured stereo sample.
- `rx_valid`  out  1  one-cycle pulse when `rx_left`/`rx_right` update.

## Operation
- **Lock synchronizer:** 2-flop synchronizer on `pll_locked` produces `lock_s`.
- **IDLE state:**
  - All outputs are 0; counters are 0; staging is empty.
  - Transition to RUN when `lock_s`=1.
- **RUN state:**
  - Return to IDLE on the cycle after `lock_s`=0. This is allowed mid-frame.
  - Staging contents and partial frames are discarded.
- **Divider:** `div_cnt` counts 0..BCLK_DIV−1.
  - `aud_bclk` is 0 for `div_cnt` < BCLK_DIV/2 and 1 otherwise.
  - The falling edge occurs at `div_cnt` wrap; the rising edge at `div_cnt`=BCLK_DIV/2.
- **Bit counter:** `bit_cnt` counts 0..2·SLOT_BITS−1 and advances on each `div_cnt` wrap.
  - LRCK = (`bit_cnt` ≥ SLOT_BITS).
  - Slot position p = `bit_cnt` mod SLOT_BITS.
- **TX (Philips I2S, one-BCLK MSB delay):**
  - For p in 1..DATA_W, `aud_dacdat` = sample[DATA_W−p]; otherwise 0.
  - Left sample in the left slot, right sample in the right slot.
  - `aud_dacdat` changes only on BCLK falling edges.
- **Frame start:** the wrap of `bit_cnt` from 2·SLOT_BITS−1 to 0.
  - If staging is full: the shift register loads the staged L/R and staging empties.
  - If staging is empty: the shift register loads zeros and `underrun` pulses.
  - The first frame after entering RUN is zeros with no underrun.
- **Handshake:**
  - `tx_ready` = RUN && staging empty.
  - An accept in the same cycle as a frame-start load fills staging for the next frame.
  - That frame-start load uses the pre-accept staging state.
- **RX:**
  - `aud_adcdat` is sampled on BCLK rising edges for p in 1..DATA_W, MSB first, into the left or right shift register per LRCK.
  - At frame start, `rx_left`/`rx_right` load the completed frame and `rx_valid` pulses.
  - No `rx_valid` for the first frame after entering RUN.

## Timing
- **Reset values:** every output is 0; state = IDLE.
- **Lock latency:** `pll_locked` rising → RUN (`tx_ready`=1) after 3 `clk` edges.
- **Unlock latency:** `pll_locked` falling → outputs 0 within 3 edges.
- **Periods:** BCLK = BCLK_DIV clk; LRCK = 2·SLOT_BITS·BCLK_DIV clk (384 at defaults).
- **TX latency:** a sample accepted during frame N plays in frame N+1.
- **RX latency:** data captured in frame N is presented at the start of N+1.
- All outputs are registered.

## Configuration
- `I2S_ADC_CAPTURE_EN` defined: RX path compiled in as described.
- Not defined:
  - RX path removed; `aud_adcdat` ignored.
  - `rx_left`/`rx_right`/`rx_valid` tied to 0.
  - `aud_adclrck` still driven identical to `aud_daclrck`.

## Test plan
- **Lock-up:** `rst` pulse, then `pll_locked`=1 → `tx_ready`=1 on the 3rd edge; BCLK period 6 clk; LRCK period 384 clk; 32 BCLKs per slot.
- **TX format:** accept L=0xA5A5A5, R=0x123456 → next frame:
  - DACDAT is 0 at p=0.
  - Bits 0xA5A5A5 MSB-first at p=1..24, then 0 for p=25..31.
  - Right slot carries 0x123456 in the same format.
- **Underrun:** no `tx_valid` → one `underrun` pulse per 384 clk; DACDAT constant 0.
- **Throughput:** `tx_valid` held at 1 → exactly one accept per 384 clk; no underrun after the first frame.
- **Loopback (`I2S_ADC_CAPTURE_EN`):** `aud_adcdat`=`aud_dacdat`, send L=0x7FFFFF, R=0x800000 → `rx_valid` at the frame start after playback with `rx_left`=0x7FFFFF, `rx_right`=0x800000.
- **Lock loss:** drop `pll_locked` mid-left-slot → outputs 0 and `tx_ready`=0 within 3 edges. On relock, LRCK restarts low and the first frame is zeros.
